// File: rtl/seq_store_ctrl.sv
// Result store with sequential readout: the producer fills entries in order, and a
// strobe steps the display through them. Errors and overflow are latched until clr.
module seq_store_ctrl #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             wr_valid,
  input  logic             wr_err,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             nxt,
  output logic [WIDTH-1:0] rd_data,
  output logic [3:0]       rd_idx,
  output logic [3:0]       count,
  output logic             full,
  output logic [1:0]       err_out,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_LOAD  = 2'b01,
    ST_FULL  = 2'b10,
    ST_ERR   = 2'b11
  } state_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  state_t           st;
  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic             wr_accept;
  logic [WIDTH-1:0] mem [DEPTH];

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  assign wr_accept = !clr && wr_valid && !wr_err && (st == ST_EMPTY || st == ST_LOAD);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_accept) begin
      mem[count] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      st      <= ST_EMPTY;
      count   <= 4'd0;
      rd_idx  <= 4'd0;
      err_out <= 2'b00;
    end else if (clr) begin
      st      <= ST_EMPTY;
      count   <= 4'd0;
      rd_idx  <= 4'd0;
      err_out <= 2'b00;
    end else begin
      // The wrap point uses the entry count from before any write on this same edge.
      if (nxt && count != 4'd0)
        rd_idx <= (rd_idx == count - 4'd1) ? 4'd0 : rd_idx + 4'd1;
      if (wr_valid && st != ST_ERR) begin
        if (wr_err) begin
          err_out[0] <= 1'b1;
          st         <= ST_ERR;
        end else if (st == ST_FULL) begin
          err_out[1] <= 1'b1;
          st         <= ST_ERR;
        end else begin
          count <= count + 4'd1;
          st    <= (count + 4'd1 == DEPTH_C) ? ST_FULL : ST_LOAD;
        end
      end
    end
  end

  assign state   = st;
  assign full    = (count == DEPTH_C);
  assign rd_data = (count != 4'd0) ? mem[rd_idx] : '0;

endmodule

// File: tb/tb_seq_store_ctrl.sv
// Directed and random checks of seq_store_ctrl against a queue-based model of the
// stored results, the readout pointer and the latched error bits.
module tb_seq_store_ctrl;

  localparam int DEPTH = 10;
  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             clr;
  logic             wr_valid;
  logic             wr_err;
  logic [WIDTH-1:0] wr_data;
  logic             nxt;
  logic [WIDTH-1:0] rd_data;
  logic [3:0]       rd_idx;
  logic [3:0]       count;
  logic             full;
  logic [1:0]       err_out;
  logic [1:0]       state;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model_q[$];
  int               model_idx;
  logic [1:0]       model_err;

  seq_store_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .wr_valid (wr_valid),
    .wr_err   (wr_err),
    .wr_data  (wr_data),
    .nxt      (nxt),
    .rd_data  (rd_data),
    .rd_idx   (rd_idx),
    .count    (count),
    .full     (full),
    .err_out  (err_out),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] model_state();
    if (model_err != 2'b00)     return 2'b11;
    if (model_q.size() == 0)    return 2'b00;
    if (model_q.size() == DEPTH) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic [WIDTH-1:0] model_rd();
    if (model_q.size() == 0) return '0;
    return model_q[model_idx];
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_idx = 0;
    model_err = 2'b00;
  endtask

  task automatic model_step(input logic c, input logic wv, input logic we,
                            input logic [WIDTH-1:0] wd, input logic n);
    int old_count;
    if (c) begin
      model_reset();
    end else begin
      old_count = model_q.size();
      if (n && old_count > 0)
        model_idx = (model_idx == old_count - 1) ? 0 : model_idx + 1;
      if (wv && model_err == 2'b00) begin
        if (we)                      model_err[0] = 1'b1;
        else if (old_count == DEPTH) model_err[1] = 1'b1;
        else                         model_q.push_back(wd);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".rd_data"}, 32'(rd_data), 32'(model_rd()));
    check({tag, ".rd_idx"},  32'(rd_idx),  32'(model_idx));
    check({tag, ".count"},   32'(count),   32'(model_q.size()));
    check({tag, ".full"},    32'(full),    32'(model_q.size() == DEPTH));
    check({tag, ".err_out"}, 32'(err_out), 32'(model_err));
    check({tag, ".state"},   32'(state),   32'(model_state()));
  endtask

  // Inputs are driven mid-cycle, applied on the next rising edge, and checked 1ns later.
  task automatic apply_stimulus(input string tag, input logic c, input logic wv,
                                input logic we, input logic [WIDTH-1:0] wd, input logic n);
    clr      = c;
    wr_valid = wv;
    wr_err   = we;
    wr_data  = wd;
    nxt      = n;
    @(posedge clk);
    #1;
    model_step(c, wv, we, wd, n);
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_err   = 1'b0;
    nxt      = 1'b0;
    check_output(tag);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) apply_stimulus("idle", 0, 0, 0, '0, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] fill_vals [3];
    fill_vals[0] = 32'h11;
    fill_vals[1] = 32'h22;
    fill_vals[2] = 32'h33;

    reset_n  = 1'b0;
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_err   = 1'b0;
    wr_data  = '0;
    nxt      = 1'b0;
    model_reset();
    #2;
    check_output("reset");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    idle(3);

    $display("[TB] fill and readout");
    for (int i = 0; i < 3; i++) apply_stimulus("fill", 0, 1, 0, fill_vals[i], 0);
    check("fill.count_abs", 32'(count), 32'd3);
    check("fill.state_abs", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) apply_stimulus("readout", 0, 0, 0, '0, 1);
    check("readout.rd_data_abs", 32'(rd_data), 32'h22);

    $display("[TB] full and overflow");
    apply_stimulus("clr", 1, 0, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus("fill10", 0, 1, 0, $urandom(), 0);
    check("full.flag_abs", 32'(full), 32'd1);
    apply_stimulus("overflow", 0, 1, 0, 32'hFF, 0);
    check("overflow.err_abs", 32'(err_out), 32'd2);
    for (int i = 0; i < DEPTH - 1; i++) apply_stimulus("ovf_view", 0, 0, 0, '0, 1);
    check("overflow.rd_idx_abs", 32'(rd_idx), 32'd9);

    $display("[TB] producer error");
    apply_stimulus("clr", 1, 0, 0, '0, 0);
    apply_stimulus("err_w0", 0, 1, 0, 32'hA0, 0);
    apply_stimulus("err_w1", 0, 1, 0, 32'hA1, 0);
    apply_stimulus("err_flag", 0, 1, 1, 32'hEE, 0);
    check("error.err_abs", 32'(err_out), 32'd1);
    apply_stimulus("err_ignored", 0, 1, 0, 32'hBB, 0);
    apply_stimulus("err_nxt1", 0, 0, 0, '0, 1);
    apply_stimulus("err_nxt2", 0, 0, 0, '0, 1);

    $display("[TB] clear priority");
    apply_stimulus("clr", 1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) apply_stimulus("prio_fill", 0, 1, 0, $urandom(), i[0]);
    apply_stimulus("prio", 1, 1, 0, 32'h55, 1);
    check("prio.count_abs", 32'(count), 32'd0);

    $display("[TB] wrap boundary");
    for (int i = 0; i < 3; i++) apply_stimulus("wrap_fill", 0, 1, 0, $urandom(), 0);
    apply_stimulus("wrap_nxt", 0, 0, 0, '0, 1);
    apply_stimulus("wrap_nxt", 0, 0, 0, '0, 1);
    apply_stimulus("wrap_wr_nxt", 0, 1, 0, 32'h44, 1);
    check("wrap.rd_idx_abs", 32'(rd_idx), 32'd0);
    apply_stimulus("clr", 1, 0, 0, '0, 0);
    apply_stimulus("empty_nxt", 0, 0, 0, '0, 1);

    $display("[TB] async reset mid-fill");
    for (int i = 0; i < 4; i++) apply_stimulus("arst_fill", 0, 1, 0, $urandom(), 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_output("async_rst");
    @(posedge clk);
    #3 reset_n = 1'b1;
    idle(3);
    apply_stimulus("post_rst_wr", 0, 1, 0, 32'hCAFE_0001, 0);
    check("post_rst.rd_data_abs", 32'(rd_data), 32'hCAFE_0001);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus("rand",
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 15) == 0),
                     $urandom(),
                     ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
